arith_iter: RTL
===============

ARITH_ITER -- requirements
Module: arith_iter

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width (legal values are 8 to 64).
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  an operation is presented on a, b, s_or_u and opcode.
REQ-005 in_ready  output  1  the block can accept an operation.
REQ-006 a, b  input  WIDTH each  operands.
REQ-007 s_or_u  input  1  1 means signed (two's complement), 0 means unsigned.
REQ-008 opcode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-009 out_valid  output  1  the result is held and valid.
REQ-010 out_ready  input  1  the consumer takes the result.
REQ-011 result  output  WIDTH  sum, difference, product low half, or quotient.
REQ-012 result_hi  output  WIDTH  product high half or remainder; zero for ADD/SUB.
REQ-013 overflow  output  1  the result is not representable.
REQ-014 div_by_zero  output  1  DIV was issued with b equal to zero.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-016 An operation is accepted on a cycle where in_valid and in_ready are both 1; the operands, s_or_u and opcode SHALL be registered on that cycle.
REQ-017 ADD/SUB SHALL go from IDLE to DONE; out_valid is asserted 1 cycle after accept.
REQ-018 ADD/SUB overflow SHALL be signed overflow when s_or_u=1, and carry-out (ADD) or borrow (SUB) when s_or_u=0.
REQ-019 MUL SHALL be iterative shift-add on operand magnitudes: one load cycle, WIDTH iteration cycles and one sign-fix cycle, so out_valid is asserted WIDTH+2 cycles after accept.
REQ-020 MUL overflow SHALL be 1 when result_hi is not the sign extension (signed) or zero extension (unsigned) of result.
REQ-021 DIV SHALL be restoring division on magnitudes with the same WIDTH+2 latency; the quotient sign is the XOR of the operand signs, and the remainder sign follows the dividend.
REQ-022 DIV with b==0 SHALL go to DONE 1 cycle after accept, with result all-ones, result_hi=a and div_by_zero=1.
REQ-023 Signed DIV of the most-negative value by -1 SHALL return result equal to the most-negative value, result_hi=0 and overflow=1, using the full latency.
REQ-024 In DONE, all outputs SHALL be held stable until out_ready=1; the FSM then returns to IDLE on that edge, and the next accept occurs no earlier than the following cycle.
REQ-025 in_valid SHALL be ignored during BUSY and DONE, with no queuing.
REQ-026 div_by_zero SHALL be 0 for all opcodes other than DIV.

Reset
REQ-027 While rst_n=0: state is IDLE, in_ready=1, out_valid=0, and result, result_hi, overflow and div_by_zero are 0.
REQ-028 Reset asserted during BUSY or DONE SHALL abort the operation without emitting a result.

Configuration
REQ-029 When macro ARITH_ITER_DIV_EN is defined, DIV SHALL be implemented as specified above.
REQ-030 When ARITH_ITER_DIV_EN is undefined, the divider datapath is absent; opcode 11 SHALL go to DONE 1 cycle after accept, with result=0, result_hi=0, overflow=1 and div_by_zero=0.

Structure
REQ-031 Package arith_iter_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV), the state enum and the default WIDTH constant.
REQ-032 Sub-module arith_iter_step SHALL implement one iteration of the shift-add or restore-subtract datapath (combinational); arith_iter holds the FSM, counter and registers.
REQ-033 The iteration counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=32)
REQ-034 ADD, unsigned, 0xFFFFFFFF + 1 -> result 0, overflow 1, out_valid at cycle 1.
REQ-035 MUL, signed, -3 * 7 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, overflow 0, out_valid at cycle 34.
REQ-036 DIV, signed, -7 / 2 -> result 0xFFFFFFFD, result_hi 0xFFFFFFFF; DIV of 0x80000000 by 0xFFFFFFFF -> result 0x80000000, overflow 1.
REQ-037 DIV, 5 / 0 -> out_valid at cycle 1, result 0xFFFFFFFF, result_hi 5, div_by_zero 1.
REQ-038 MUL, unsigned, 0x10000 * 0x10000 with out_ready held low for 5 cycles -> result 0, result_hi 1, overflow 1, outputs stable throughout, in_ready low until 1 cycle after the handshake.
REQ-039 rst_n pulsed low at iteration 10 of a MUL -> out_valid never asserts, all outputs 0, and a following ADD 2+3 returns 5.

Source files
------------

// File: rtl/arith_iter_pkg.sv
// Shared types for the iterative ADD/SUB/MUL/DIV unit.
// DIV datapath is built only when ARITH_ITER_DIV_EN is defined.
package arith_iter_pkg;

    localparam int ARITH_ITER_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/arith_iter_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Divide step exists only when ARITH_ITER_DIV_EN is defined.
module arith_iter_step
    import arith_iter_pkg::*;
#(
    parameter int WIDTH = ARITH_ITER_WIDTH
) (
`ifdef ARITH_ITER_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_sum;

    // {carry, acc, lo} shifts right one place per step
    assign w_sum = {1'b0, i_acc} + {1'b0, (i_lo[0] ? i_m : '0)};

`ifdef ARITH_ITER_DIV_EN
    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_diff;

    assign w_sh   = {i_acc, i_lo[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, i_m};

    always_comb begin
        o_acc = w_sum[WIDTH:1];
        o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
        if (i_div) begin
            // borrow set: restore the shifted remainder, quotient bit 0
            o_acc = w_diff[WIDTH] ? w_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
            o_lo  = {i_lo[WIDTH-2:0], ~w_diff[WIDTH]};
        end
    end
`else
    assign o_acc = w_sum[WIDTH:1];
    assign o_lo  = {w_sum[0], i_lo[WIDTH-1:1]};
`endif

endmodule

// File: rtl/arith_iter.sv
// Iterative arithmetic unit: single-cycle ADD/SUB, WIDTH+2 cycle MUL/DIV.
// Define ARITH_ITER_DIV_EN to build the restoring divider.
module arith_iter
    import arith_iter_pkg::*;
#(
    parameter int WIDTH = ARITH_ITER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s_or_u,
    input  logic [1:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    state_e           r_state;
    logic             r_su;
    logic             r_neg_q;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_ovf;
    logic             r_dbz;

    op_e              w_op;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic [WIDTH-1:0] w_step_acc;
    logic [WIDTH-1:0] w_step_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic             w_mul_ovf;

    assign w_op    = op_e'(opcode);
    assign w_a_neg = s_or_u & a[WIDTH-1];
    assign w_b_neg = s_or_u & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};

    assign w_add_ovf = s_or_u
        ? ((a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]))
        : w_add[WIDTH];
    assign w_sub_ovf = s_or_u
        ? ((a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]))
        : w_sub[WIDTH];

    assign w_prod = r_neg_q ? -{r_acc, r_lo} : {r_acc, r_lo};
    assign w_mul_ovf = r_su
        ? (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}})
        : (w_prod[2*WIDTH-1:WIDTH] != '0);

`ifdef ARITH_ITER_DIV_EN
    logic             r_is_div;
    logic             r_neg_r;
    logic             r_div_ovf;
    logic             w_div_ovf;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_rem;

    // most-negative / -1 yields the most-negative value naturally
    assign w_div_ovf = s_or_u && (a == {1'b1, {(WIDTH-1){1'b0}}})
                       && (b == '1);
    assign w_quo = r_neg_q ? -r_lo : r_lo;
    assign w_rem = r_neg_r ? -r_acc : r_acc;
`endif

    arith_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
`ifdef ARITH_ITER_DIV_EN
        .i_div (r_is_div),
`endif
        .i_acc (r_acc),
        .i_lo  (r_lo),
        .i_m   (r_m),
        .o_acc (w_step_acc),
        .o_lo  (w_step_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_su        <= 1'b0;
            r_neg_q     <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_ovf       <= 1'b0;
            r_dbz       <= 1'b0;
`ifdef ARITH_ITER_DIV_EN
            r_is_div    <= 1'b0;
            r_neg_r     <= 1'b0;
            r_div_ovf   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_su        <= s_or_u;
                        r_neg_q     <= w_a_neg ^ w_b_neg;
                        r_cnt       <= '0;
                        r_acc       <= '0;
                        r_lo        <= w_a_mag;
                        r_m         <= w_b_mag;
                        r_result_hi <= '0;
                        r_ovf       <= 1'b0;
                        r_dbz       <= 1'b0;
`ifdef ARITH_ITER_DIV_EN
                        r_is_div    <= (w_op == OP_DIV);
                        r_neg_r     <= w_a_neg;
                        r_div_ovf   <= w_div_ovf;
`endif
                        unique case (w_op)
                            OP_ADD: begin
                                r_result <= w_add[WIDTH-1:0];
                                r_ovf    <= w_add_ovf;
                                r_state  <= ST_DONE;
                            end
                            OP_SUB: begin
                                r_result <= w_sub[WIDTH-1:0];
                                r_ovf    <= w_sub_ovf;
                                r_state  <= ST_DONE;
                            end
                            OP_MUL: begin
                                r_state <= ST_BUSY;
                            end
                            OP_DIV: begin
`ifdef ARITH_ITER_DIV_EN
                                if (b == '0) begin
                                    r_result    <= '1;
                                    r_result_hi <= a;
                                    r_dbz       <= 1'b1;
                                    r_state     <= ST_DONE;
                                end else begin
                                    r_state <= ST_BUSY;
                                end
`else
                                r_result <= '0;
                                r_ovf    <= 1'b1;
                                r_state  <= ST_DONE;
`endif
                            end
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != LAST) begin
                        r_acc <= w_step_acc;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        // sign-fix cycle
`ifdef ARITH_ITER_DIV_EN
                        if (r_is_div) begin
                            r_result    <= w_quo;
                            r_result_hi <= w_rem;
                            r_ovf       <= r_div_ovf;
                        end else begin
                            r_result    <= w_prod[WIDTH-1:0];
                            r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                            r_ovf       <= w_mul_ovf;
                        end
`else
                        r_result    <= w_prod[WIDTH-1:0];
                        r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_ovf       <= w_mul_ovf;
`endif
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign result_hi   = r_result_hi;
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule
